// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce_pkg
//
// Shared constants and types for the push-button debouncer.
//
//   DEBOUNCE_CNT_20MS_12MHZ : default stability window (20 ms at 12 MHz)
//   DEBOUNCE_CNT_SIM        : short window used by simulation benches
//   cnt_act_e               : per-edge action taken on the stability counter
//   inactive_level()        : idle level of the raw button for a polarity
// ---------------------------------------------------------------------------
package key_debounce_pkg;

    localparam int DEBOUNCE_CNT_20MS_12MHZ = 240000;
    localparam int DEBOUNCE_CNT_SIM        = 4;

    // What the stability counter does on the next clock edge.
    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,  // synchronized input agrees with debounced state
        CNT_INC    = 2'd1,  // input differs, window not yet complete
        CNT_ACCEPT = 2'd2   // input differed for the whole window: take it
    } cnt_act_e;

    // Level the button reads when nobody is pressing it.
    function automatic logic inactive_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/key_sync.sv
// ---------------------------------------------------------------------------
// key_sync
//
// Two-flop synchronizer for one asynchronous level. The flops are chained
// directly with nothing in between, so the first flop is free to settle
// from metastability before the second one samples it.
//
// Parameters:
//   RST_VAL : value both flops take in reset
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   d   : asynchronous input level
//   q   : synchronized level (two clocks of latency)
// ---------------------------------------------------------------------------
module key_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Debounces one mechanical push-button and emits a single-clock pulse for
// each accepted press. The raw level is synchronized, then a change is only
// accepted once the synchronized level has disagreed with the debounced
// state for CNT_MAX consecutive clocks. Any return to the debounced value
// during that window restarts the count.
//
// A clean change seen at edge k is accepted (state and key_pulse update)
// at edge k+1+CNT_MAX: two edges through the synchronizer and CNT_MAX
// edges of counting, the last of which overlaps the acceptance.
//
// Optional build macro:
//   KEY_DEBOUNCE_LEVEL_OUT_EN : adds key_level, the debounced state with
//                               1 = pressed regardless of polarity.
//
// Parameters:
//   CNT_MAX    : stability window in clocks (>= 2)
//   ACTIVE_LOW : 1 = button reads 0 when pressed, 0 = reads 1 when pressed
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   key       : raw asynchronous button level
//   key_pulse : one-cycle high pulse per accepted press
//   key_level : (optional) debounced level, 1 = pressed, 0 in reset
// ---------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   CNT_MAX    = DEBOUNCE_CNT_20MS_12MHZ,
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
    output logic key_level,
`endif
    output logic key_pulse
);

    localparam int            CW         = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CNT_MAX - 1);
    localparam logic          IDLE_LVL   = inactive_level(ACTIVE_LOW);
    localparam logic          ACTIVE_LVL = ~IDLE_LVL;

    logic          key_s;      // synchronized button level
    logic          state;      // debounced button level (raw polarity)
    logic          state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_nxt;
    cnt_act_e      act;

    key_sync #(
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key),
        .q   (key_s)
    );

    // Decide what the counter does this cycle.
    always_comb begin
        act = CNT_CLEAR;
        if (key_s != state) begin
            if (cnt == CNT_LAST) begin
                act = CNT_ACCEPT;
            end else begin
                act = CNT_INC;
            end
        end
    end

    // Next values for counter, debounced state and pulse.
    always_comb begin
        cnt_nxt   = '0;
        state_nxt = state;
        pulse_nxt = 1'b0;
        unique case (act)
            CNT_CLEAR: begin
                cnt_nxt = '0;
            end
            CNT_INC: begin
                cnt_nxt = cnt + CW'(1);
            end
            CNT_ACCEPT: begin
                cnt_nxt   = '0;
                state_nxt = key_s;
                // Only the inactive-to-active transition is a press; an
                // accepted release updates the state silently.
                pulse_nxt = (key_s == ACTIVE_LVL);
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE_LVL;
            cnt       <= '0;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_pulse <= pulse_nxt;
        end
    end

`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
    // Driven only by the state flop, so there is still no path from key.
    assign key_level = state ^ ACTIVE_LOW;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//
// Two debouncer instances with CNT_MAX = 4: u_lo (button pressed = 0) and
// u_hi (button pressed = 1). Stimulus changes the key on the falling edge
// and, when a pulse is due, pushes the cycle number on which key_pulse must
// be seen into that instance's expected queue. A separate monitor samples
// key_pulse on every falling edge: a pulse must coincide with the queue
// head, and no pulse may appear anywhere else.
//
// A key change driven when `cyc` posedges have elapsed is first sampled at
// edge cyc+1 (= k); the pulse rises at edge k+5 and so is seen at the
// falling edge where cyc == k+5, i.e. cyc+6 at drive time.
// ---------------------------------------------------------------------------
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int CNT     = DEBOUNCE_CNT_SIM;
    localparam int LATENCY = CNT + 2;

    logic clk;
    logic rst;
    logic key_a;
    logic key_b;
    logic pulse_a;
    logic pulse_b;
`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
    logic level_a;
    logic level_b;
`endif

    int unsigned cyc;
    int          n_cmp;
    int          n_err;

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    key_debounce #(
        .CNT_MAX    (CNT),
        .ACTIVE_LOW (1'b1)
    ) u_lo (
        .clk       (clk),
        .rst       (rst),
        .key       (key_a),
`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
        .key_level (level_a),
`endif
        .key_pulse (pulse_a)
    );

    key_debounce #(
        .CNT_MAX    (CNT),
        .ACTIVE_LOW (1'b0)
    ) u_hi (
        .clk       (clk),
        .rst       (rst),
        .key       (key_b),
`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
        .key_level (level_b),
`endif
        .key_pulse (pulse_b)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive key_a on a falling edge; optionally expect a press pulse.
    task automatic drive_a(input logic v, input bit expect_pulse);
        @(negedge clk);
        key_a = v;
        if (expect_pulse) exp_q_a.push_back(32'(cyc + LATENCY));
    endtask

    task automatic drive_b(input logic v, input bit expect_pulse);
        @(negedge clk);
        key_b = v;
        if (expect_pulse) exp_q_b.push_back(32'(cyc + LATENCY));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        automatic logic exp_a = (exp_q_a.size() != 0) && (exp_q_a[0] == 32'(cyc));
        automatic logic exp_b = (exp_q_b.size() != 0) && (exp_q_b[0] == 32'(cyc));

        n_cmp++;
        if (pulse_a !== exp_a) begin
            n_err++;
            $display("FAIL pulse_lo cycle %0d: got %b, expected %b", cyc, pulse_a, exp_a);
        end
        if (exp_a) void'(exp_q_a.pop_front());

        n_cmp++;
        if (pulse_b !== exp_b) begin
            n_err++;
            $display("FAIL pulse_hi cycle %0d: got %b, expected %b", cyc, pulse_b, exp_b);
        end
        if (exp_b) void'(exp_q_b.pop_front());

`ifdef KEY_DEBOUNCE_LEVEL_OUT_EN
        if (rst) begin
            n_cmp++;
            if (level_a !== 1'b0 || level_b !== 1'b0) begin
                n_err++;
                $display("FAIL level_reset cycle %0d: got %b%b, expected 00", cyc, level_a, level_b);
            end
        end
`endif
    end

    // ---------------- sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        key_a = 1'b0;   // pressed level while in reset
        key_b = 1'b0;

        // Reset held 3 clocks with key_a pressed: no pulse.
        step(3);
        rst   = 1'b0;
        key_a = 1'b1;
        step(20);

        // Clean press, then hold 50 more cycles: exactly one pulse.
        drive_a(1'b0, 1'b1);
        step(LATENCY + 50);

        // Release (accepted, silent), then bounce 0,1,0,1 x 2 clocks.
        drive_a(1'b1, 1'b0);
        step(10);
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 1'b0);
            step(1);
            drive_a(1'b1, 1'b0);
            step(1);
        end
        step(6);
        // Final press after the bounce: one pulse.
        drive_a(1'b0, 1'b1);
        step(20);

        // Release for 6 clocks, then re-press: second pulse.
        drive_a(1'b1, 1'b0);
        step(5);
        drive_a(1'b0, 1'b1);
        step(20);

        // Release, then press and reset when the counter reaches 2.
        drive_a(1'b1, 1'b0);
        step(10);
        drive_a(1'b0, 1'b0);  // edges: +1 sync1, +2 sync2, +3 cnt=1, +4 cnt=2
        step(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q_a.push_back(32'(cyc + LATENCY));
        step(20);

        // Active-high instance: press pulses, release does not.
        drive_b(1'b1, 1'b1);
        step(20);
        drive_b(1'b0, 1'b0);
        step(20);

        // Nothing expected may be left outstanding.
        n_cmp++;
        if (exp_q_a.size() != 0) begin
            n_err++;
            $display("FAIL queue_lo: %0d pulses never seen, expected 0", exp_q_a.size());
        end
        n_cmp++;
        if (exp_q_b.size() != 0) begin
            n_err++;
            $display("FAIL queue_hi: %0d pulses never seen, expected 0", exp_q_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
